// File: rtl/mcdf_pkg.sv
// Shared types and constants for the MCDF arbiter: FSM states, channel count
// and the packet-length code decode.
package mcdf_pkg;

  localparam int CH_NUM = 3;
  localparam int LEN_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_e;

  localparam logic [2:0] LEN_CODE_4  = 3'd0;
  localparam logic [2:0] LEN_CODE_8  = 3'd1;
  localparam logic [2:0] LEN_CODE_16 = 3'd2;

  // Codes 3..7 all collapse to the 32-word maximum packet.
  function automatic logic [LEN_W-1:0] len_decode(input logic [2:0] code);
    logic [LEN_W-1:0] words;
    case (code)
      LEN_CODE_4:  words = 6'd4;
      LEN_CODE_8:  words = 6'd8;
      LEN_CODE_16: words = 6'd16;
      default:     words = 6'd32;
    endcase
    return words;
  endfunction

endpackage

// File: rtl/mcdf_arbiter_if.sv
// Slave-FIFO and formatter signal bundle for the MCDF arbiter; the master
// modport is the arbiter side, the slave modport is the FIFO/formatter side.
interface mcdf_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
);

  logic [mcdf_pkg::CH_NUM-1:0]                 slv_en;
  logic [mcdf_pkg::CH_NUM-1:0][1:0]            slv_prio;
  logic [mcdf_pkg::CH_NUM-1:0][2:0]            slv_len;
  logic [mcdf_pkg::CH_NUM-1:0]                 slv_req;
  logic [mcdf_pkg::CH_NUM-1:0]                 slv_val;
  logic [mcdf_pkg::CH_NUM-1:0][DATA_WIDTH-1:0] slv_data;
  logic [mcdf_pkg::CH_NUM-1:0]                 slv_ack;

  logic                  fmt_req;
  logic [1:0]            fmt_id;
  logic [CNT_WIDTH-1:0]  fmt_length;
  logic                  fmt_grant;
  logic                  fmt_rdy;
  logic                  fmt_val;
  logic [DATA_WIDTH-1:0] fmt_data;
  logic                  fmt_start;
  logic                  fmt_end;

  modport master (
    input  slv_en, slv_prio, slv_len, slv_req, slv_val, slv_data,
    input  fmt_grant, fmt_rdy,
    output slv_ack, fmt_req, fmt_id, fmt_length, fmt_val, fmt_data,
    output fmt_start, fmt_end
  );

  modport slave (
    output slv_en, slv_prio, slv_len, slv_req, slv_val, slv_data,
    output fmt_grant, fmt_rdy,
    input  slv_ack, fmt_req, fmt_id, fmt_length, fmt_val, fmt_data,
    input  fmt_start, fmt_end
  );

endinterface

// File: rtl/mcdf_prio_rr_pick.sv
// Combinational winner selection: lowest priority value wins, ties broken
// round-robin starting from the channel after the last winner.
module mcdf_prio_rr_pick
  import mcdf_pkg::*;
(
  input  logic [CH_NUM-1:0]      i_elig,
  input  logic [CH_NUM-1:0][1:0] i_prio,
  input  logic [1:0]             i_rr_last,
  output logic [1:0]             o_win_id,
  output logic                   o_win_valid
);

  logic [1:0] w_idx;
  logic [1:0] w_best_prio;
  logic [1:0] w_win_id;
  logic       w_win_valid;

  // Strict less-than keeps the earliest channel in search order on a tie.
  always_comb begin
    w_win_id    = 2'd0;
    w_win_valid = 1'b0;
    w_best_prio = 2'd3;
    w_idx       = (i_rr_last >= 2'd2) ? 2'd0 : i_rr_last + 2'd1;
    for (int i = 0; i < CH_NUM; i++) begin
      if (i_elig[w_idx] && (!w_win_valid || (i_prio[w_idx] < w_best_prio))) begin
        w_win_id    = w_idx;
        w_win_valid = 1'b1;
        w_best_prio = i_prio[w_idx];
      end else begin
        w_win_id    = w_win_id;
      end
      w_idx = (w_idx >= 2'd2) ? 2'd0 : w_idx + 2'd1;
    end
  end

  assign o_win_id    = w_win_id;
  assign o_win_valid = w_win_valid;

endmodule

// File: rtl/mcdf_arbiter.sv
// MCDF arbiter: picks one slave channel per packet, handshakes with the
// formatter, then streams the packet words under formatter backpressure.
module mcdf_arbiter
  import mcdf_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  mcdf_arbiter_if.master bus
);

  state_e                r_state;
  state_e                w_next;
  logic [1:0]            r_win_id;
  logic [1:0]            r_rr_last;
  logic [CNT_WIDTH-1:0]  r_len;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic [CH_NUM-1:0]     w_elig;
  logic [1:0]            w_pick_id;
  logic                  w_pick_valid;
  logic [CNT_WIDTH-1:0]  w_pick_len;
  logic                  w_sel_val;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_xfer;
  logic [CH_NUM-1:0]     w_ack;
  logic                  w_req;
  logic                  w_val;
  logic                  w_start;
  logic                  w_end;
  logic [DATA_WIDTH-1:0] w_data;

  assign w_elig     = bus.slv_en & bus.slv_req;
  assign w_pick_len = CNT_WIDTH'(len_decode(bus.slv_len[w_pick_id]));

  mcdf_prio_rr_pick u_pick (
    .i_elig      (w_elig),
    .i_prio      (bus.slv_prio),
    .i_rr_last   (r_rr_last),
    .o_win_id    (w_pick_id),
    .o_win_valid (w_pick_valid)
  );

  // Head word of the locked channel.
  always_comb begin
    case (r_win_id)
      2'd0:    begin w_sel_val = bus.slv_val[0]; w_sel_data = bus.slv_data[0]; end
      2'd1:    begin w_sel_val = bus.slv_val[1]; w_sel_data = bus.slv_data[1]; end
      2'd2:    begin w_sel_val = bus.slv_val[2]; w_sel_data = bus.slv_data[2]; end
      default: begin w_sel_val = 1'b0;           w_sel_data = '0;              end
    endcase
  end

  assign w_xfer = (r_state == ST_XFER) && bus.fmt_rdy && w_sel_val;

  // Next state and all handshake/datapath outputs.
  always_comb begin
    w_next  = r_state;
    w_req   = 1'b0;
    w_val   = 1'b0;
    w_start = 1'b0;
    w_end   = 1'b0;
    w_data  = '0;
    w_ack   = 3'b000;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_next = ST_REQ;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_REQ: begin
        w_req = 1'b1;
        if (bus.fmt_grant) begin
          w_next = ST_XFER;
        end else begin
          w_next = ST_REQ;
        end
      end
      ST_XFER: begin
        w_val   = w_sel_val;
        w_data  = w_sel_data;
        w_start = w_sel_val && (r_cnt == r_len);
        w_end   = w_sel_val && (r_cnt == CNT_WIDTH'(1));
        if (w_xfer) begin
          case (r_win_id)
            2'd0:    w_ack = 3'b001;
            2'd1:    w_ack = 3'b010;
            2'd2:    w_ack = 3'b100;
            default: w_ack = 3'b000;
          endcase
        end else begin
          w_ack = 3'b000;
        end
        if (w_xfer && (r_cnt == CNT_WIDTH'(1))) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_XFER;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State, packet lock registers and word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_win_id  <= 2'd0;
      r_rr_last <= 2'd2;
      r_len     <= '0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && w_pick_valid) begin
        r_win_id <= w_pick_id;
        r_len    <= w_pick_len;
        r_cnt    <= w_pick_len;
      end else if (w_xfer) begin
        r_cnt <= r_cnt - CNT_WIDTH'(1);
        if (r_cnt == CNT_WIDTH'(1)) begin
          r_rr_last <= r_win_id;
        end
      end
    end
  end

  assign bus.fmt_req    = w_req;
  assign bus.fmt_id     = r_win_id;
  assign bus.fmt_length = r_len;
  assign bus.fmt_val    = w_val;
  assign bus.fmt_data   = w_data;
  assign bus.fmt_start  = w_start;
  assign bus.fmt_end    = w_end;
  assign bus.slv_ack    = w_ack;

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Directed bench for mcdf_arbiter: arbitration order, handshake timing,
// backpressure, packet lock and asynchronous reset.
module tb_mcdf_arbiter;
  import mcdf_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   idx[CH_NUM];

  mcdf_arbiter_if #(.DATA_WIDTH(32), .CNT_WIDTH(6)) bus ();

  mcdf_arbiter #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int n);
    return {8'(n), 24'(idx[n])};
  endfunction

  task automatic drive_data();
    for (int n = 0; n < CH_NUM; n++) bus.slv_data[n] = word_of(n);
  endtask

  task automatic set_ch(input int n, input logic en, input logic [1:0] prio,
                        input logic [2:0] len, input logic req);
    bus.slv_en[n]   = en;
    bus.slv_prio[n] = prio;
    bus.slv_len[n]  = len;
    bus.slv_req[n]  = req;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(tag, {bus.fmt_req, bus.fmt_val, bus.fmt_start, bus.fmt_end, bus.slv_ack,
              bus.fmt_id, bus.fmt_length, bus.fmt_data}, 64'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.fmt_grant = 1'b0;
      bus.fmt_rdy   = 1'b0;
      bus.slv_val   = 3'b111;
      drive_data();
      #1;
      chk("idle_out", {bus.fmt_req, bus.fmt_val, bus.slv_ack, bus.fmt_data}, 64'd0);
    end
  endtask

  // One packet: wait for fmt_req, grant after gdly REQ cycles, then stream.
  // pat 1 toggles fmt_rdy and drops the winner's val in cycles 5..7.
  task automatic run_packet(input logic [1:0] id, input int words, input int gdly,
                            input int pat, input int exp_wait, input int lock_at,
                            input int abort_at);
    int         waited;
    int         xf;
    logic       rdy;
    logic [2:0] val;
    logic [2:0] exp_ack;
    logic       xfer;
    waited = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.fmt_grant = (gdly == 0);
      bus.fmt_rdy   = 1'b0;
      bus.slv_val   = 3'b111;
      drive_data();
      #1;
      if (bus.fmt_req) break;
      waited++;
    end
    chk("req_wait", 64'(waited), 64'(exp_wait));
    if (!bus.fmt_req) return;
    chk("req_fields", {bus.fmt_req, bus.fmt_val, bus.fmt_id, bus.fmt_length},
        {1'b1, 1'b0, id, 6'(words)});
    for (int g = 1; g <= gdly; g++) begin
      @(negedge clk);
      bus.fmt_grant = (g == gdly);
      #1;
      chk("req_hold", {bus.fmt_req, bus.fmt_val, bus.fmt_id, bus.fmt_length},
          {1'b1, 1'b0, id, 6'(words)});
    end
    xf = 0;
    for (int cyc = 0; (xf < words) && (cyc < 200); cyc++) begin
      if (xf == abort_at) return;
      @(negedge clk);
      if (xf == lock_at) begin
        bus.slv_en[0]   = 1'b0;
        bus.slv_prio[1] = 2'd0;
      end
      bus.fmt_grant = 1'b0;
      rdy = (pat == 1) ? ((cyc % 2) == 0) : 1'b1;
      val = 3'b111;
      if ((pat == 1) && (cyc >= 5) && (cyc <= 7)) val[id] = 1'b0;
      bus.fmt_rdy = rdy;
      bus.slv_val = val;
      drive_data();
      #1;
      xfer    = rdy & val[id];
      exp_ack = xfer ? (3'b001 << id) : 3'b000;
      chk("xfer_ctl", {bus.fmt_req, bus.fmt_val, bus.fmt_start, bus.fmt_end, bus.slv_ack},
          {1'b0, val[id], val[id] && (xf == 0), val[id] && (xf == words - 1), exp_ack});
      if (val[id]) chk("xfer_data", 64'(bus.fmt_data), 64'(word_of(id)));
      if (xfer) begin
        idx[id]++;
        xf++;
      end
    end
    chk("word_count", 64'(xf), 64'(words));
  endtask

  initial begin
    for (int n = 0; n < CH_NUM; n++) idx[n] = 0;
    rst_n         = 1'b0;
    bus.slv_en    = 3'b000;
    bus.slv_prio  = '0;
    bus.slv_len   = '0;
    bus.slv_req   = 3'b000;
    bus.slv_val   = 3'b111;
    bus.fmt_grant = 1'b0;
    bus.fmt_rdy   = 1'b1;
    drive_data();
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Round-robin tie from reset: 0,1,2,0 with a bubble between packets.
    for (int n = 0; n < CH_NUM; n++) set_ch(n, 1'b1, 2'd1, 3'd0, 1'b1);
    run_packet(2'd0, 4, 0, 0, 0, -1, -1);
    run_packet(2'd1, 4, 0, 0, 1, -1, -1);
    run_packet(2'd2, 4, 0, 0, 1, -1, -1);
    run_packet(2'd0, 4, 0, 0, 1, -1, -1);
    for (int n = 0; n < CH_NUM; n++) set_ch(n, 1'b0, 2'd0, 3'd0, 1'b0);
    idle_cycles(2);

    // Single channel, grant two cycles after request.
    set_ch(1, 1'b1, 2'd2, 3'd0, 1'b1);
    run_packet(2'd1, 4, 2, 0, 0, -1, -1);
    set_ch(1, 1'b0, 2'd0, 3'd0, 1'b0);
    idle_cycles(2);

    // Priority: ch2 (prio 0) before ch0 (prio 3).
    set_ch(0, 1'b1, 2'd3, 3'd1, 1'b1);
    set_ch(2, 1'b1, 2'd0, 3'd1, 1'b1);
    run_packet(2'd2, 8, 0, 0, 0, -1, -1);
    bus.slv_req[2] = 1'b0;
    run_packet(2'd0, 8, 1, 0, 1, -1, -1);
    set_ch(0, 1'b0, 2'd0, 3'd0, 1'b0);
    set_ch(2, 1'b0, 2'd0, 3'd0, 1'b0);
    idle_cycles(2);

    // Backpressure on a 16-word packet.
    set_ch(0, 1'b1, 2'd0, 3'd2, 1'b1);
    run_packet(2'd0, 16, 1, 1, 0, -1, -1);
    set_ch(0, 1'b0, 2'd0, 3'd0, 1'b0);
    idle_cycles(2);

    // Lock: ch0 disabled and ch1 promoted mid-packet; ch2 enabled without req.
    set_ch(0, 1'b1, 2'd1, 3'd3, 1'b1);
    set_ch(1, 1'b1, 2'd2, 3'd0, 1'b1);
    set_ch(2, 1'b1, 2'd0, 3'd0, 1'b0);
    run_packet(2'd0, 32, 0, 0, 0, 3, -1);
    run_packet(2'd1, 4, 0, 0, 1, -1, -1);
    bus.slv_req[1] = 1'b0;
    idle_cycles(4);

    // Reset after the fifth word of an 8-word packet.
    set_ch(0, 1'b1, 2'd0, 3'd1, 1'b1);
    set_ch(1, 1'b0, 2'd0, 3'd0, 1'b0);
    set_ch(2, 1'b0, 2'd0, 3'd0, 1'b0);
    run_packet(2'd0, 8, 0, 0, 0, -1, 5);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    for (int n = 0; n < CH_NUM; n++) set_ch(n, 1'b1, 2'd1, 3'd0, 1'b1);
    @(negedge clk);
    #1;
    chk_reset_outputs("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    run_packet(2'd0, 4, 0, 0, 0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mcdf_arbiter.md
Name: mcdf_arbiter

Overview:
- Shares the single formatter output path among the three slave channel FIFOs.
- Arbitrates using the per-channel enable, priority and packet-length fields driven by the control register block.
- Once a channel wins, it holds the grant for one whole packet, negotiates with the formatter through a request/grant handshake, then streams the packet words with backpressure.

Parameters:
- DATA_WIDTH, 32, width of each slave data word and of fmt_data.
- CNT_WIDTH, 6, width of the word counter; must hold a count of 32.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- slvN_en (N=0..2)  in  1  channel enable from the register block.
- slvN_prio (N=0..2)  in  2  channel priority; 0 is highest.
- slvN_len (N=0..2)  in  3  packet length code.
- slvN_req (N=0..2)  in  1  FIFO holds at least one full packet.
- slvN_val (N=0..2)  in  1  FIFO head word valid (show-ahead).
- slvN_data (N=0..2)  in  DATA_WIDTH  FIFO head word.
- slvN_ack (N=0..2)  out  1  pop strobe to the FIFO.
- fmt_req  out  1  packet request to the formatter.
- fmt_id  out  2  granted channel id.
- fmt_length  out  CNT_WIDTH  decoded packet length in words.
- fmt_grant  in  1  formatter accepts the request.
- fmt_rdy  in  1  formatter can take a word this cycle.
- fmt_val  out  1  fmt_data valid.
- fmt_data  out  DATA_WIDTH  packet word.
- fmt_start  out  1  first word of the packet.
- fmt_end  out  1  last word of the packet.

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk.
- On reset:
  - state=IDLE, rr_last=2, so ch0 wins the first tie.
  - All outputs 0: fmt_req, fmt_val, fmt_start, fmt_end, slvN_ack, fmt_id, fmt_length, fmt_data.
- Length decode: code 0→4, 1→8, 2→16, 3..7→32 words.
- Eligibility: elig[N] = slvN_en & slvN_req.
- State IDLE:
  - If any channel is eligible, pick the eligible channel with the numerically lowest prio.
  - Priority ties go round-robin, searching from (rr_last+1) mod 3.
  - Latch win_id and its decoded length into registers, load cnt=length, go to REQ.
  - If no channel is eligible, stay in IDLE.
- State REQ:
  - fmt_req=1; fmt_id=win_id and fmt_length=latched length, both from registers.
  - fmt_grant=1 in this state (including the first REQ cycle) → XFER next cycle.
  - Otherwise hold REQ indefinitely; outputs stay stable.
- State XFER:
  - fmt_val = slv[win_id]_val.
  - fmt_data = slv[win_id]_data (combinational mux, zero latency).
  - A word is transferred in a cycle where fmt_rdy & slv[win_id]_val.
  - In a transfer cycle: slv[win_id]_ack=1 and cnt decrements.
  - All other acks are always 0.
  - fmt_start=1 on fmt_val while cnt==length; fmt_end=1 on fmt_val while cnt==1.
  - Transfer with cnt==1 → IDLE, rr_last=win_id.
  - fmt_rdy=0 or val=0: no ack, no count; output holds.
- In IDLE and REQ: fmt_val=0, fmt_data=0.
- Packet lock: changes to slvN_en, slvN_prio, slvN_len or slvN_req after the IDLE decision have no effect until the next IDLE. This holds even if the granted channel is disabled mid-packet.
- Back-to-back: after the last word, at least one IDLE cycle before the next fmt_req, i.e. 1-cycle arbitration bubble.
- Reset mid-packet: abort immediately to the reset state; no further acks. The partial packet is the formatter's/FIFO's concern.
- Illegal state encoding → IDLE.

Decomposition:
- mcdf_pkg holds:
  - state encodings IDLE/REQ/XFER;
  - CH_NUM=3;
  - the length-code constants;
  - a function decoding len code to word count.
- One sub-module, mcdf_prio_rr_pick: purely combinational.
  - Inputs: elig[2:0], three prios, rr_last.
  - Outputs: win_id[1:0] and win_valid.
- The FSM, counter and datapath mux stay in mcdf_arbiter.

Test Plan:
- Single channel: slv1_en=1, req=1, len=0, prio=2; fmt_grant 2 cycles after fmt_req; fmt_rdy=1 → fmt_id=1, fmt_length=4, exactly 4 fmt_val words with start on #1 and end on #4, 4 slv1_ack pulses, return to IDLE.
- Priority: ch0 prio=3, ch2 prio=0, both eligible, len=1 → ch2 packet (8 words) first, then ch0.
- Round-robin tie: all three prio=1, req held continuously, len=0 → grant order 0,1,2,0; one IDLE cycle between packets.
- Backpressure: len=2 (16 words); fmt_rdy toggles 1,0,1,0 and slv0_val drops for 3 cycles mid-packet → exactly 16 acks, each only when fmt_rdy&val; fmt_end on the 16th word.
- Lock and disable: during ch0 XFER, set slv0_en=0 and slv1 prio=0 → ch0 finishes all 32 words (len=3); ch0 not re-granted afterwards; ch1 next. Also: en=1, req=0 → never granted.
- Reset mid-operation: rst_n low in XFER after word 5 → all outputs 0 asynchronously, state IDLE; after release, ch0 wins a 3-way tie (rr_last=2).
